// File: rtl/cnn_pkg.sv
// Shared CNN pipeline definitions: output geometry, TX handshake states and FIFO entry layout.
package cnn_pkg;

  localparam int unsigned IMG_DIM    = 28;
  localparam int unsigned OUT_DIM    = IMG_DIM - 2;
  localparam int unsigned FRAME_BITS = OUT_DIM * OUT_DIM;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned BIT_IDX_W  = $clog2(BYTE_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } tx_state_t;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } tx_entry_t;

  localparam int unsigned ENTRY_W = $bits(tx_entry_t);

  function automatic tx_entry_t make_entry(input logic [BYTE_W-1:0] data, input logic last);
    tx_entry_t e;
    e.last = last;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/cnn_byte_fifo.sv
// Small synchronous FIFO with count-based full/empty and first-word-fallthrough read data.
module cnn_byte_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cnn_tx_packer.sv
// Packs the core's 1-bit result stream LSB-first into bytes, queues them and
// feeds the UART through a trmt/tx_done handshake with frame-complete tagging.
module cnn_tx_packer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FRAME_BITS = cnn_pkg::FRAME_BITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       din_vld,
  output logic       din_rdy,
  input  logic       flush,
  output logic [7:0] tx_data,
  output logic       trmt,
  input  logic       tx_done,
  output logic       bsy,
  output logic       frame_done
);

  import cnn_pkg::*;

  localparam int unsigned FC_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_BITS - 1);
  localparam logic [BIT_IDX_W-1:0] BIT_LAST = BIT_IDX_W'(BYTE_W - 1);

  logic [BIT_IDX_W-1:0] cnt_8;
  logic [FC_W-1:0]      cnt_frame;
  logic [BYTE_W-1:0]    shreg;
  logic [BYTE_W-1:0]    byte_w;

  logic      accept;
  logic      flush_s;
  logic      byte_full;
  logic      frame_end;
  logic      flush_push;
  logic      close_frame;
  logic      push;
  logic      pop;
  logic      fifo_full;
  logic      fifo_empty;
  tx_entry_t push_entry;
  tx_entry_t head;

  tx_state_t tx_state;
  logic      last_r;

  assign din_rdy = !fifo_full;
  assign bsy     = (tx_state != IDLE) || !fifo_empty || (cnt_8 != '0);
  assign pop     = (tx_state == IDLE) && !fifo_empty;

  // Byte assembly: the bit accepted this cycle is merged before any push decision.
  always_comb begin
    accept     = din_vld && din_rdy;
    flush_s    = flush && din_rdy;
    byte_w     = shreg;
    if (accept) begin
      byte_w[cnt_8] = din;
    end
    byte_full   = accept && (cnt_8 == BIT_LAST);
    frame_end   = accept && (cnt_frame == FC_LAST);
    flush_push  = flush_s && ((cnt_8 != '0) || accept);
    close_frame = frame_end || flush_push;
    push        = byte_full || close_frame;
    push_entry  = make_entry(byte_w, close_frame);
  end

  // Unused high bits of shreg stay zero, which provides the padding of short bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_8     <= '0;
      cnt_frame <= '0;
      shreg     <= '0;
    end else if (close_frame) begin
      cnt_8     <= '0;
      cnt_frame <= '0;
      shreg     <= '0;
    end else if (flush_s) begin
      cnt_frame <= '0;
    end else if (accept) begin
      cnt_8     <= cnt_8 + BIT_IDX_W'(1);
      cnt_frame <= cnt_frame + FC_W'(1);
      shreg     <= byte_full ? '0 : byte_w;
    end
  end

  cnn_byte_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // TX handshake: IDLE loads the head byte, SEND strobes trmt, WAIT holds until tx_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state   <= IDLE;
      tx_data    <= '0;
      last_r     <= 1'b0;
      trmt       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      trmt       <= 1'b0;
      frame_done <= 1'b0;
      case (tx_state)
        IDLE: begin
          if (!fifo_empty) begin
            tx_data  <= head.data;
            last_r   <= head.last;
            trmt     <= 1'b1;
            tx_state <= SEND;
          end
        end
        SEND: begin
          tx_state <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            frame_done <= last_r;
            tx_state   <= IDLE;
          end
        end
        default: begin
          tx_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_tx_packer.sv
// Directed bench for cnn_tx_packer with a byte-level reference model and a UART responder.
module tb_cnn_tx_packer;

  localparam int FB    = 676;
  localparam int DEPTH = 8;

  typedef struct {
    logic [7:0] d;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic       din_vld;
  logic       din_rdy;
  logic       flush;
  logic [7:0] tx_data;
  logic       trmt;
  logic       tx_done = 1'b0;
  logic       bsy;
  logic       frame_done;

  cnn_tx_packer #(
    .FIFO_DEPTH (DEPTH),
    .FRAME_BITS (FB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_vld    (din_vld),
    .din_rdy    (din_rdy),
    .flush      (flush),
    .tx_data    (tx_data),
    .trmt       (trmt),
    .tx_done    (tx_done),
    .bsy        (bsy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic void chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference model: bytes built from accepted bits by position, frame and flush rules.
  exp_t       exp_q[$];
  logic [7:0] tx_log[$];
  int         m_nb = 0;
  int         m_fc = 0;
  logic [7:0] m_acc = 8'h00;

  function automatic void emit(input logic last);
    exp_t e;
    e.d = m_acc;
    e.last = last;
    exp_q.push_back(e);
    m_acc = 8'h00;
    m_nb = 0;
    if (last) m_fc = 0;
  endfunction

  function automatic void model_cycle(input logic acc, input logic b, input logic fl);
    if (acc) begin
      m_acc[m_nb] = b;
      m_nb++;
      m_fc++;
    end
    if (fl && m_nb != 0) emit(1'b1);
    else if (fl) m_fc = 0;
    else if (acc && m_fc == FB) emit(1'b1);
    else if (acc && m_nb == 8) emit(1'b0);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_nb = 0;
    m_fc = 0;
    m_acc = 8'h00;
  endfunction

  // UART responder and per-cycle output checker.
  logic hold_tx = 1'b0;
  int   tx_delay = 10;
  int   done_at_cyc = -1;
  logic in_flight = 1'b0;
  logic fd_exp = 1'b0;
  int   cd = 0;
  int   trmt_cnt = 0;
  int   fd_cnt = 0;
  int   trmt_cyc = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_flight = 1'b0;
      fd_exp = 1'b0;
      tx_done = 1'b0;
      cd = 0;
    end else begin
      chk("frame_done", int'(frame_done), int'(fd_exp));
      fd_exp = 1'b0;
      if (frame_done) fd_cnt++;
      tx_done = 1'b0;
      if (trmt) begin
        chk("trmt_overlap", int'(in_flight), 0);
        if (exp_q.size() == 0) begin
          chk("spurious_trmt", int'(trmt), 0);
          cur.d = tx_data;
          cur.last = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          chk("tx_data", int'(tx_data), int'(cur.d));
        end
        tx_log.push_back(tx_data);
        trmt_cnt++;
        trmt_cyc = cyc;
        in_flight = 1'b1;
        cd = tx_delay;
      end else if (in_flight) begin
        chk("tx_hold", int'(tx_data), int'(cur.d));
        if (!hold_tx && cd > 0) cd--;
        if ((!hold_tx && cd == 0) || cyc == done_at_cyc) begin
          tx_done = 1'b1;
          fd_exp = cur.last;
          in_flight = 1'b0;
        end
      end
    end
  end

  int last_acc_cyc = 0;

  task automatic put_bit(input logic b, input logic fl);
    int w = 0;
    @(negedge clk);
    while (!din_rdy && w < 2000) begin
      din_vld = 1'b0;
      flush = 1'b0;
      w++;
      @(negedge clk);
    end
    chk("din_rdy_timeout", int'(w >= 2000), 0);
    din = b;
    din_vld = 1'b1;
    flush = fl;
    model_cycle(1'b1, b, fl);
    last_acc_cyc = cyc;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) put_bit(v[i], 1'b0);
  endtask

  task automatic do_flush();
    @(negedge clk);
    din_vld = 1'b0;
    flush = din_rdy;
    if (din_rdy) model_cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle_in(input int n);
    repeat (n) begin
      @(negedge clk);
      din_vld = 1'b0;
      flush = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((exp_q.size() != 0 || in_flight || bsy) && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk("drain_timeout", int'(c >= 5000), 0);
    repeat (3) @(negedge clk);
    chk("bsy_idle", int'(bsy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int tc0, fd0, lg0, acc;
  logic [7:0] pat;
  logic [7:0] b8;

  initial begin
    rst_n = 1'b0;
    din = 1'b0;
    din_vld = 1'b0;
    flush = 1'b0;
    #2;
    chk("rst_trmt", int'(trmt), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_bsy", int'(bsy), 0);
    chk("rst_din_rdy", int'(din_rdy), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single byte 1,0,1,1,0,0,0,0 with tx_done 10 cycles after trmt
    tx_delay = 10;
    tc0 = trmt_cnt; fd0 = fd_cnt; lg0 = tx_log.size();
    pat = 8'b0000_1101;
    for (int i = 0; i < 8; i++) put_bit(pat[i], 1'b0);
    idle_in(1);
    wait_drain();
    chk("single_trmt_count", trmt_cnt - tc0, 1);
    chk("single_byte", int'(tx_log[lg0]), 8'h0D);
    chk("single_latency", trmt_cyc - last_acc_cyc, 2);
    chk("single_no_frame_done", fd_cnt - fd0, 0);

    // Flush with empty partial byte only clears the frame count
    tc0 = trmt_cnt; fd0 = fd_cnt;
    do_flush();
    idle_in(6);
    chk("empty_flush_no_trmt", trmt_cnt - tc0, 0);
    chk("empty_flush_no_fd", fd_cnt - fd0, 0);
    chk("empty_flush_bsy", int'(bsy), 0);

    // Full frame of ones
    tx_delay = 5;
    tc0 = trmt_cnt; fd0 = fd_cnt; lg0 = tx_log.size();
    for (int i = 0; i < FB; i++) put_bit(1'b1, 1'b0);
    idle_in(1);
    wait_drain();
    chk("frame_trmt_count", trmt_cnt - tc0, 85);
    chk("frame_first_byte", int'(tx_log[lg0]), 8'hFF);
    chk("frame_last_byte", int'(tx_log[tx_log.size()-1]), 8'h0F);
    chk("frame_done_count", fd_cnt - fd0, 1);

    // Partial flush 1,1,1 then an alternating frame from fresh counters
    fd0 = fd_cnt;
    for (int i = 0; i < 3; i++) put_bit(1'b1, 1'b0);
    do_flush();
    idle_in(1);
    wait_drain();
    chk("flush_byte", int'(tx_log[tx_log.size()-1]), 8'h07);
    chk("flush_frame_done", fd_cnt - fd0, 1);
    tc0 = trmt_cnt; fd0 = fd_cnt; lg0 = tx_log.size();
    for (int i = 0; i < FB; i++) put_bit(logic'(i % 2 == 0), 1'b0);
    idle_in(1);
    wait_drain();
    chk("alt_first_byte", int'(tx_log[lg0]), 8'h55);
    chk("alt_last_byte", int'(tx_log[tx_log.size()-1]), 8'h05);
    chk("alt_trmt_count", trmt_cnt - tc0, 85);
    chk("alt_frame_done", fd_cnt - fd0, 1);

    // Flush coincident with an accepted 4th bit
    fd0 = fd_cnt;
    for (int i = 0; i < 3; i++) put_bit(1'b1, 1'b0);
    put_bit(1'b1, 1'b1);
    idle_in(1);
    wait_drain();
    chk("flush_4th_bit", int'(tx_log[tx_log.size()-1]), 8'h0F);
    chk("flush_4th_fd", fd_cnt - fd0, 1);

    // Backpressure: UART stalled, stream until the packer refuses
    hold_tx = 1'b1;
    fd0 = fd_cnt;
    acc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!din_rdy) begin
        din_vld = 1'b0;
        break;
      end
      b8 = 8'($urandom);
      din = b8[0];
      din_vld = 1'b1;
      flush = 1'b0;
      model_cycle(1'b1, b8[0], 1'b0);
      acc++;
    end
    chk("bp_accepted_bits", acc, 72);
    repeat (5) begin
      @(negedge clk);
      din_vld = 1'b0;
      chk("bp_rdy_low", int'(din_rdy), 0);
    end
    hold_tx = 1'b0;
    for (int i = 0; i < 100; i++) begin
      b8 = 8'($urandom);
      put_bit(b8[0], 1'b0);
    end
    do_flush();
    idle_in(1);
    wait_drain();
    chk("bp_frame_done", fd_cnt - fd0, 1);

    // Push landing in the same cycle as the IDLE pop
    hold_tx = 1'b1;
    lg0 = tx_log.size();
    send_byte(8'h3C);
    send_byte(8'hC3);
    pat = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      put_bit(pat[i], 1'b0);
      if (i == 5) done_at_cyc = cyc + 1;
    end
    idle_in(1);
    hold_tx = 1'b0;
    wait_drain();
    done_at_cyc = -1;
    chk("pp_count", int'(tx_log.size()) - lg0, 3);
    chk("pp_byte0", int'(tx_log[lg0]), 8'h3C);
    chk("pp_byte1", int'(tx_log[lg0+1]), 8'hC3);
    chk("pp_byte2", int'(tx_log[lg0+2]), 8'h5A);

    // Reset while WAIT holds a byte and three more are queued
    hold_tx = 1'b1;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    idle_in(4);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_trmt", int'(trmt), 0);
    chk("mid_rst_tx_data", int'(tx_data), 0);
    chk("mid_rst_bsy", int'(bsy), 0);
    chk("mid_rst_din_rdy", int'(din_rdy), 1);
    chk("mid_rst_frame_done", int'(frame_done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold_tx = 1'b0;
    tc0 = trmt_cnt;
    send_byte(8'hA5);
    idle_in(1);
    wait_drain();
    chk("post_rst_count", trmt_cnt - tc0, 1);
    chk("post_rst_byte", int'(tx_log[tx_log.size()-1]), 8'hA5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
